add_image_axis_block_gen: RTL and testbench



---
 rtl/add_image_axis_block_gen.sv | 115 +++++++++++
 tb/tb_add_image_axis_block_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/add_image_axis_block_gen.sv
// add_image_axis_block_gen
// Watches the TVALID/TREADY pair of each monitored AXI-Stream channel and
// raises a per-channel block bit once the channel has been stalled for
// STALL_THRESH consecutive cycles. The first channel to block is captured
// sticky for debug readback until clear or reset.
// Optional build macro: ADD_IMAGE_AXIS_BLOCK_STATS_EN adds a saturating
// 32-bit count of cycles with any block asserted (otherwise block_cycles=0).
module add_image_axis_block_gen #(
    parameter int                NUM_CH       = 5,
    parameter int                STALL_THRESH = 16,
    parameter logic [NUM_CH-1:0] DIR_MASK     = 5'b00011
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic [NUM_CH-1:0] ch_tvalid,
    input  logic [NUM_CH-1:0] ch_tready,
    output logic [NUM_CH-1:0] axis_block_sigs,
    output logic              any_block,
    output logic              first_valid,
    output logic [4:0]        first_idx,
    output logic [31:0]       block_cycles
);

    localparam int            CW     = $clog2(STALL_THRESH + 1);
    localparam logic [CW-1:0] THRESH = CW'(STALL_THRESH);

    logic [NUM_CH-1:0] stall;
    logic [NUM_CH-1:0] blk_now;
    logic [NUM_CH-1:0] blk_next;
    logic [NUM_CH-1:0] rise;
    logic [4:0]        rise_idx;
    logic              first_valid_reg;
    logic [4:0]        first_idx_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;

            // Readers stall when starved, writers stall when backpressured;
            // a transfer (valid & ready) is never a stall in either role.
            assign stall[gi] = DIR_MASK[gi] ? (ch_tready[gi] & ~ch_tvalid[gi])
                                            : (ch_tvalid[gi] & ~ch_tready[gi]);

            // Consecutive-stall count: cleared when disabled or on any non-stall cycle
            always_comb begin
                cnt_next = '0;
                if (enable && stall[gi]) begin
                    cnt_next = (cnt_reg == THRESH) ? cnt_reg : cnt_reg + 1'b1;
                end
            end

            // Counter register
            always_ff @(posedge clock) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign blk_now[gi]  = (cnt_reg == THRESH);
            assign blk_next[gi] = (cnt_next == THRESH);
        end
    endgenerate

    // Block bits that will rise on the coming edge
    assign rise = blk_next & ~blk_now;

    // Lowest-index rising channel wins when several block together
    always_comb begin
        rise_idx = 5'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rise[i]) begin
                rise_idx = 5'(i);
            end
        end
    end

    // Sticky first-block capture; clear beats a simultaneous rise
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            first_valid_reg <= 1'b0;
            first_idx_reg   <= 5'd0;
        end else if (!first_valid_reg && (|rise)) begin
            first_valid_reg <= 1'b1;
            first_idx_reg   <= rise_idx;
        end
    end

    assign axis_block_sigs = blk_now;
    assign any_block       = |blk_now;
    assign first_valid     = first_valid_reg;
    assign first_idx       = first_idx_reg;

`ifdef ADD_IMAGE_AXIS_BLOCK_STATS_EN
    logic [31:0] block_cycles_reg;

    // Saturating count of edges seen with any block asserted
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            block_cycles_reg <= 32'd0;
        end else if (any_block && !(&block_cycles_reg)) begin
            block_cycles_reg <= block_cycles_reg + 32'd1;
        end
    end

    assign block_cycles = block_cycles_reg;
`else
    assign block_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_add_image_axis_block_gen.sv
// Testbench for add_image_axis_block_gen: directed scenarios plus a random
// phase, with expected outputs queued per driven cycle and compared after
// the corresponding edge.
module tb_add_image_axis_block_gen;

    localparam int         NCH = 5;
    localparam int         TH  = 16;
    localparam logic [4:0] DIR = 5'b00011;

    logic           clock;
    logic           reset;
    logic           enable;
    logic           clear;
    logic [NCH-1:0] ch_tvalid;
    logic [NCH-1:0] ch_tready;
    logic [NCH-1:0] axis_block_sigs;
    logic           any_block;
    logic           first_valid;
    logic [4:0]     first_idx;
    logic [31:0]    block_cycles;

    add_image_axis_block_gen #(
        .NUM_CH       (NCH),
        .STALL_THRESH (TH),
        .DIR_MASK     (DIR)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .clear           (clear),
        .ch_tvalid       (ch_tvalid),
        .ch_tready       (ch_tready),
        .axis_block_sigs (axis_block_sigs),
        .any_block       (any_block),
        .first_valid     (first_valid),
        .first_idx       (first_idx),
        .block_cycles    (block_cycles)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [4:0]  blk;
        logic        any;
        logic        fv;
        logic [4:0]  idx;
        logic [31:0] bc;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;

    // reference model state
    int          m_cnt[NCH];
    logic        m_fv;
    logic [4:0]  m_idx;
    longint      m_bc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle, push the model's prediction, then compare after the edge
    task automatic step(input logic rst, input logic en, input logic clr,
                        input logic [4:0] tv, input logic [4:0] tr);
        logic [4:0] pb, nb, rs;
        logic       st;
        exp_t       e, o;
        reset = rst; enable = en; clear = clr; ch_tvalid = tv; ch_tready = tr;
        pb = '0;
        for (int i = 0; i < NCH; i++) pb[i] = (m_cnt[i] == TH);
        if (rst) begin
            for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
            m_fv = 1'b0; m_idx = 5'd0; m_bc = 0;
        end else begin
            nb = '0;
            for (int i = 0; i < NCH; i++) begin
                st = DIR[i] ? (tr[i] && !tv[i]) : (tv[i] && !tr[i]);
                if (!en || !st) m_cnt[i] = 0;
                else if (m_cnt[i] < TH) m_cnt[i] = m_cnt[i] + 1;
                nb[i] = (m_cnt[i] == TH);
            end
            rs = nb & ~pb;
            if (clr) begin
                m_fv = 1'b0; m_idx = 5'd0;
            end else if (!m_fv && rs != 0) begin
                m_fv = 1'b1;
                for (int i = NCH - 1; i >= 0; i--) if (rs[i]) m_idx = 5'(i);
            end
`ifdef ADD_IMAGE_AXIS_BLOCK_STATS_EN
            if (clr) m_bc = 0;
            else if (pb != 0 && m_bc < 64'hFFFF_FFFF) m_bc = m_bc + 1;
`else
            m_bc = 0;
`endif
        end
        for (int i = 0; i < NCH; i++) e.blk[i] = (m_cnt[i] == TH);
        e.any = |e.blk;
        e.fv  = m_fv;
        e.idx = m_idx;
        e.bc  = m_bc[31:0];
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            o = sb_q.pop_front();
            check("blk", 32'(axis_block_sigs), 32'(o.blk));
            check("any", 32'(any_block), 32'(o.any));
            check("fv",  32'(first_valid), 32'(o.fv));
            check("idx", 32'(first_idx), 32'(o.idx));
            check("bc",  block_cycles, o.bc);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, 5'b0, 5'b0);
    endtask

    initial begin
        logic [4:0] tv, tr;
        reset = 1'b1; enable = 1'b0; clear = 1'b0; ch_tvalid = '0; ch_tready = '0;
        for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
        m_fv = 1'b0; m_idx = 5'd0; m_bc = 0;

        // reset state
        step(1'b1, 1'b0, 1'b0, 5'b0, 5'b0);
        step(1'b1, 1'b1, 1'b0, 5'b11111, 5'b11111);
        check("rst_blk", 32'(axis_block_sigs), 32'd0);
        check("rst_fv", 32'(first_valid), 32'd0);
        check("rst_bc", block_cycles, 32'd0);
        idle(2);

        // input ch0 starved: blocks on the 16th edge, not the 15th
        for (int k = 0; k < 15; k++) step(1'b0, 1'b1, 1'b0, 5'b00000, 5'b00001);
        check("ch0_at15", 32'(axis_block_sigs), 32'd0);
        step(1'b0, 1'b1, 1'b0, 5'b00000, 5'b00001);
        check("ch0_at16", 32'(axis_block_sigs), 32'b00001);
        check("ch0_fv", 32'(first_valid), 32'd1);
        check("ch0_idx", 32'(first_idx), 32'd0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 5'b00000, 5'b00001);
        // one transfer cycle drops the block
        step(1'b0, 1'b1, 1'b0, 5'b00001, 5'b00001);
        check("ch0_fall", 32'(any_block), 32'd0);
        check("ch0_fv_kept", 32'(first_valid), 32'd1);
        step(1'b0, 1'b1, 1'b1, 5'b0, 5'b0);
        check("clr_fv", 32'(first_valid), 32'd0);

        // output ch3: 15 stalls, a transfer, then 20 stalls
        for (int k = 0; k < 15; k++) step(1'b0, 1'b1, 1'b0, 5'b01000, 5'b00000);
        check("ch3_run1", 32'(axis_block_sigs), 32'd0);
        step(1'b0, 1'b1, 1'b0, 5'b01000, 5'b01000);
        for (int k = 0; k < 15; k++) step(1'b0, 1'b1, 1'b0, 5'b01000, 5'b00000);
        check("ch3_run2_15", 32'(axis_block_sigs), 32'd0);
        step(1'b0, 1'b1, 1'b0, 5'b01000, 5'b00000);
        check("ch3_run2_16", 32'(axis_block_sigs), 32'b01000);
        check("ch3_idx", 32'(first_idx), 32'd3);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 5'b01000, 5'b00000);
        step(1'b0, 1'b1, 1'b1, 5'b0, 5'b0);

        // ch1 and ch4 together; later ch2 does not move first_idx
        for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 1'b0, 5'b10000, 5'b00010);
        check("dual_blk", 32'(axis_block_sigs), 32'b10010);
        check("dual_idx", 32'(first_idx), 32'd1);
        for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 1'b0, 5'b10100, 5'b00010);
        check("ch2_blk", 32'(axis_block_sigs), 32'b10110);
        check("ch2_idx", 32'(first_idx), 32'd1);
        step(1'b0, 1'b1, 1'b1, 5'b0, 5'b0);

        // enable drop mid-stall restarts the count
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b0, 5'b00000, 5'b00001);
        step(1'b0, 1'b0, 1'b0, 5'b00000, 5'b00001);
        for (int k = 0; k < 15; k++) step(1'b0, 1'b1, 1'b0, 5'b00000, 5'b00001);
        check("en_15", 32'(axis_block_sigs), 32'd0);
        step(1'b0, 1'b1, 1'b0, 5'b00000, 5'b00001);
        check("en_16", 32'(axis_block_sigs), 32'b00001);
        // reset while blocked
        step(1'b1, 1'b1, 1'b0, 5'b00000, 5'b00001);
        check("rst_mid_blk", 32'(axis_block_sigs), 32'd0);
        check("rst_mid_fv", 32'(first_valid), 32'd0);

        // stats: hold a block for 100 cycles, then clear
        for (int k = 0; k < 116; k++) step(1'b0, 1'b1, 1'b0, 5'b00000, 5'b00001);
`ifdef ADD_IMAGE_AXIS_BLOCK_STATS_EN
        check("stats_100", block_cycles, 32'd100);
`else
        check("stats_off", block_cycles, 32'd0);
`endif
        step(1'b0, 1'b1, 1'b1, 5'b00000, 5'b00001);
        check("stats_clr", block_cycles, 32'd0);
        idle(2);

        // random phase with slowly changing handshakes
        tv = '0; tr = '0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 19) == 0) tv = 5'($urandom);
            if ($urandom_range(0, 19) == 0) tr = 5'($urandom);
            step($urandom_range(0, 249) == 0, $urandom_range(0, 39) != 0,
                 $urandom_range(0, 59) == 0, tv, tr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
